// File: rtl/mips32_pkg.sv
// +--------------------------------------------------------------------+
// | mips32_pkg : shared MIPS32 opcode constants and fetch defaults     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mips32_pkg;

  localparam int ADDR_W_DEF = 10;

  // Opcode field occupies the top six bits of every instruction word.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [5:0] OP_HLT   = 6'b111111;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;

endpackage

`default_nettype wire

// File: rtl/mips32_ifq_fifo.sv
// +--------------------------------------------------------------------+
// | mips32_ifq_fifo : synchronous FIFO with occupancy count and flush  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mips32_ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_wr, do_rd;

  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_rd   = rd_en && (count_q != '0);
  assign do_wr   = wr_en && ((count_q != FULL_CNT) || do_rd);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_q + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mips32_ifetch_queue.sv
// +--------------------------------------------------------------------+
// | mips32_ifetch_queue : MIPS32 fetch front end, buffers {IR,NPC}     |
// | Optional macro IFQ_BYPASS_EN: same-cycle reply forwarding to ID.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mips32_ifetch_queue
  import mips32_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_ir,
  output logic [31:0]       id_npc,
  input  logic              id_ready
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam int                QW      = DATA_W + ADDR_W;
  localparam logic [CNT_W:0]    CREDITS = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic              stop_q, stop_d;

  logic              accept, resp, drop, take, bypass, hlt;
  logic              q_push, q_pop, q_valid;
  logic [QW-1:0]     q_rdata;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] tag_addr, tag_npc;
  logic [CNT_W-1:0]  tag_count;

  // Replies with nothing outstanding are stale (e.g. issued before reset).
  assign resp    = imem_rvalid && (inflight_q != '0);
  assign drop    = resp && (discard_q != '0);
  assign take    = resp && !drop && !redirect_valid && (tag_count != '0);
  assign hlt     = take && (imem_rdata[OPC_MSB:OPC_LSB] == OP_HLT);
  assign tag_npc = tag_addr + PC_ONE;
  assign q_valid = (q_count != '0);

  assign imem_req  = rst_n && !halt && !stop_q && !redirect_valid &&
                     (({1'b0, inflight_q} + {1'b0, q_count}) < CREDITS);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;

`ifdef IFQ_BYPASS_EN
  assign bypass = take && !q_valid && id_ready;
`else
  assign bypass = 1'b0;
`endif

  assign q_push   = take && !bypass;
  assign q_pop    = q_valid && id_ready && !redirect_valid;
  assign id_valid = q_valid || bypass;

  always_comb begin
    id_ir  = '0;
    id_npc = '0;
    if (bypass) begin
      id_ir  = imem_rdata;
      id_npc = {{(32-ADDR_W){1'b0}}, tag_npc};
    end else if (q_valid) begin
      id_ir  = q_rdata[QW-1:ADDR_W];
      id_npc = {{(32-ADDR_W){1'b0}}, q_rdata[ADDR_W-1:0]};
    end
  end

  // After a redirect or HLT every request still outstanding is wrong-path,
  // including one granted in the HLT cycle itself.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(resp);
    discard_d  = discard_q;
    stop_d     = stop_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      discard_d = inflight_d;
      stop_d    = 1'b0;
    end else begin
      if (accept) begin
        pc_d = pc_q + PC_ONE;
      end
      if (hlt) begin
        discard_d = inflight_d;
        stop_d    = 1'b1;
      end else if (drop) begin
        discard_d = discard_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      stop_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      stop_q     <= stop_d;
    end
  end

  mips32_ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_data_q (
    .clk     (clk1),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (q_push),
    .wr_data ({imem_rdata, tag_npc}),
    .rd_en   (q_pop),
    .rd_data (q_rdata),
    .count   (q_count)
  );

  mips32_ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_q (
    .clk     (clk1),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .wr_en   (accept),
    .wr_data (pc_q),
    .rd_en   (take),
    .rd_data (tag_addr),
    .count   (tag_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips32_ifetch_queue.sv
// +--------------------------------------------------------------------+
// | tb_mips32_ifetch_queue : vector table, corner sequences, random    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mips32_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        halt;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic        id_ready;

  always #5 clk1 = ~clk1;

  mips32_ifetch_queue dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_valid       (id_valid),
    .id_ir          (id_ir),
    .id_npc         (id_npc),
    .id_ready       (id_ready)
  );

  typedef struct packed {logic [31:0] ir; logic [9:0] npc;} ent_t;
  typedef struct packed {logic [9:0] addr; logic drop;} req_t;
  typedef struct {
    bit gnt; bit rv; logic [31:0] rdata; bit ready;
    bit e_req; logic [9:0] e_addr; bit e_valid; logic [31:0] e_ir; logic [31:0] e_npc;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [1024];
  int          pend[$];
  ent_t        m_q[$];
  req_t        m_out[$];
  logic [9:0]  m_pc;
  bit          m_stop;

  int k_gnt_pct, k_rv_pct, k_ready_pct, k_halt_pct;
  bit k_stray;
  bit s_req, s_valid;
  logic [9:0]  s_addr;
  logic [31:0] s_ir, s_npc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_out.delete();
    pend.delete();
    m_pc   = '0;
    m_stop = 1'b0;
  endtask

  task automatic quiet_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; halt = 0; id_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet_inputs();
    model_clear();
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, check model expectations, advance model at posedge.
  task automatic cyc(input bit redir, input logic [9:0] rpc);
    bit resp, e_req, byp, e_valid, acc, hlt;
    logic [31:0] e_ir, e_npc;
    req_t head;
    ent_t ne;
    imem_gnt = ($urandom_range(99) < k_gnt_pct);
    if (pend.size() > 0) imem_rvalid = ($urandom_range(99) < k_rv_pct);
    else                 imem_rvalid = k_stray;
    if (!imem_rvalid)        imem_rdata = $urandom;
    else if (pend.size() > 0) imem_rdata = mem[pend[0]];
    else                      imem_rdata = 32'hfc000000;
    id_ready = ($urandom_range(99) < k_ready_pct);
    halt = ($urandom_range(99) < k_halt_pct);
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    resp = imem_rvalid && (m_out.size() > 0);
    head = '0;
    if (resp) head = m_out[0];
    e_req = !halt && !m_stop && !redir && (m_out.size() + m_q.size() < DEPTH);
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = resp && !head.drop && (m_q.size() == 0) && id_ready && !redir;
`endif
    e_valid = (m_q.size() > 0) || byp;
    if (byp) begin
      e_ir = imem_rdata; e_npc = {22'd0, head.addr + 10'd1};
    end else if (m_q.size() > 0) begin
      e_ir = m_q[0].ir; e_npc = {22'd0, m_q[0].npc};
    end else begin
      e_ir = '0; e_npc = '0;
    end
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (e_req) chk("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc});
    chk("id_valid", {31'd0, id_valid}, {31'd0, e_valid});
    if (e_valid) begin
      chk("id_ir", id_ir, e_ir);
      chk("id_npc", id_npc, e_npc);
    end
    s_req = imem_req; s_valid = id_valid; s_addr = imem_addr; s_ir = id_ir; s_npc = id_npc;
    acc = e_req && imem_gnt;
    @(posedge clk1);
    if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
    if (acc) pend.push_back(int'(m_pc));
    hlt = 1'b0;
    if (resp) void'(m_out.pop_front());
    if (redir) begin
      m_q.delete();
      foreach (m_out[i]) m_out[i].drop = 1'b1;
      m_pc = rpc;
      m_stop = 1'b0;
    end else begin
      if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
      if (resp && !head.drop) begin
        ne.ir = imem_rdata;
        ne.npc = head.addr + 10'd1;
        if (!byp) m_q.push_back(ne);
        hlt = (imem_rdata[31:26] == 6'h3f);
      end
      if (acc) begin
        m_out.push_back('{addr: m_pc, drop: 1'b0});
        m_pc = m_pc + 10'd1;
      end
      if (hlt) begin
        m_stop = 1'b1;
        foreach (m_out[i]) m_out[i].drop = 1'b1;
      end
    end
    @(negedge clk1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc(1'b0, 10'd0);
      found = s_valid;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_req(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc(1'b0, 10'd0);
      found = s_req;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[6];
    int n;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      if (mem[i][31:26] == 6'h3f) mem[i][31] = 1'b0;
    end
    mem[0] = 32'h280a00c8; mem[1] = 32'h28020001; mem[2] = 32'h0e94a000;
    mem[8] = 32'h3460fffc; mem[10] = 32'hfc000000;
    k_gnt_pct = 100; k_rv_pct = 100; k_ready_pct = 100; k_halt_pct = 0; k_stray = 0;

    rst_n = 1'b0;
    quiet_inputs();
    model_clear();
    repeat (2) @(negedge clk1);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_ir", id_ir, 32'd0);
    chk("rst_id_npc", id_npc, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;

    // Three back-to-back fetches with single-cycle reply latency.
`ifdef IFQ_BYPASS_EN
    tv[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 10'd0, 1'b0, 32'h0,        32'd0};
    tv[1] = '{1'b1, 1'b1, 32'h280a00c8, 1'b1, 1'b1, 10'd1, 1'b1, 32'h280a00c8, 32'd1};
    tv[2] = '{1'b1, 1'b1, 32'h28020001, 1'b1, 1'b1, 10'd2, 1'b1, 32'h28020001, 32'd2};
    tv[3] = '{1'b0, 1'b1, 32'h0e94a000, 1'b1, 1'b1, 10'd3, 1'b1, 32'h0e94a000, 32'd3};
    tv[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 10'd3, 1'b0, 32'h0,        32'd0};
    tv[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 10'd3, 1'b0, 32'h0,        32'd0};
`else
    tv[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 10'd0, 1'b0, 32'h0,        32'd0};
    tv[1] = '{1'b1, 1'b1, 32'h280a00c8, 1'b1, 1'b1, 10'd1, 1'b0, 32'h0,        32'd0};
    tv[2] = '{1'b1, 1'b1, 32'h28020001, 1'b1, 1'b1, 10'd2, 1'b1, 32'h280a00c8, 32'd1};
    tv[3] = '{1'b0, 1'b1, 32'h0e94a000, 1'b1, 1'b1, 10'd3, 1'b1, 32'h28020001, 32'd2};
    tv[4] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 10'd3, 1'b1, 32'h0e94a000, 32'd3};
    tv[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 10'd3, 1'b0, 32'h0,        32'd0};
`endif
    for (int i = 0; i < 6; i++) begin
      imem_gnt = tv[i].gnt; imem_rvalid = tv[i].rv; imem_rdata = tv[i].rdata;
      id_ready = tv[i].ready; halt = 0; redirect_valid = 0; redirect_pc = '0;
      #1;
      chk("tv_imem_req", {31'd0, imem_req}, {31'd0, tv[i].e_req});
      chk("tv_imem_addr", {22'd0, imem_addr}, {22'd0, tv[i].e_addr});
      chk("tv_id_valid", {31'd0, id_valid}, {31'd0, tv[i].e_valid});
      if (tv[i].e_valid || i == 0) begin
        chk("tv_id_ir", id_ir, tv[i].e_ir);
        chk("tv_id_npc", id_npc, tv[i].e_npc);
      end
      @(posedge clk1);
      @(negedge clk1);
    end

    // Credit limit: decode stalled, exactly DEPTH accepts, then drain.
    do_reset();
    k_ready_pct = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 10'd0);
      if (s_req) n++;
    end
    chk("credit_accepts", n, 32'd4);
    chk("credit_req_low", {31'd0, s_req}, 32'd0);
    k_ready_pct = 100;
    repeat (8) cyc(1'b0, 10'd0);

    // Redirect with two fetches in flight.
    do_reset();
    k_rv_pct = 0;
    repeat (2) cyc(1'b0, 10'd0);
    cyc(1'b1, 10'h008);
    k_rv_pct = 100;
    wait_valid("redir_seen", 20);
    chk("redir_ir", s_ir, 32'h3460fffc);
    chk("redir_npc", s_npc, 32'd9);

    // HLT stops fetching until the next redirect.
    cyc(1'b1, 10'd10);
    wait_valid("hlt_seen", 20);
    chk("hlt_ir", s_ir, 32'hfc000000);
    chk("hlt_npc", s_npc, 32'd11);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 10'd0);
      if (s_req) n++;
    end
    chk("hlt_no_req", n, 32'd0);
    cyc(1'b1, 10'd0);
    wait_req("hlt_restart", 10);
    chk("hlt_restart_addr", {22'd0, s_addr}, 32'd0);

    // PC wrap at the top of the address space.
    cyc(1'b1, 10'h3ff);
    wait_valid("wrap_first", 20);
    chk("wrap_npc0", s_npc, 32'd0);
    cyc(1'b0, 10'd0);
    if (!s_valid) wait_valid("wrap_second", 20);
    chk("wrap_npc1", s_npc, 32'd1);

    // Asynchronous reset mid-stream, then stale replies ignored.
    k_rv_pct = 0;
    repeat (2) cyc(1'b0, 10'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
    quiet_inputs();
    model_clear();
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    k_rv_pct = 100; k_halt_pct = 100; k_stray = 1;
    repeat (3) cyc(1'b0, 10'd0);
    k_halt_pct = 0; k_stray = 0;
    wait_req("post_rst_req", 5);
    chk("post_rst_addr", {22'd0, s_addr}, 32'd0);

    // Randomized traffic against the reference model.
    mem[100] = 32'hfc000123; mem[517] = 32'hfc000000; mem[1000] = 32'hfc00ffff;
    k_gnt_pct = 70; k_rv_pct = 60; k_ready_pct = 70; k_halt_pct = 8;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 3) begin
        if ($urandom_range(3) == 0) cyc(1'b1, 10'(10'h3fc + $urandom_range(3)));
        else                        cyc(1'b1, 10'($urandom_range(1023)));
      end else begin
        cyc(1'b0, 10'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
